// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator (800x600@72 Hz defaults)
// plus the coordinate type and the helper that sums one axis into its total.
package vga_timing_pkg;

   localparam int COORD_W   = 11;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   typedef logic [COORD_W-1:0] coordT;

   localparam int DEF_H_VISIBLE = 800;
   localparam int DEF_H_FRONT   = 56;
   localparam int DEF_H_SYNC    = 120;
   localparam int DEF_H_BACK    = 64;
   localparam int DEF_V_VISIBLE = 600;
   localparam int DEF_V_FRONT   = 37;
   localparam int DEF_V_SYNC    = 6;
   localparam int DEF_V_BACK    = 23;

   // One axis is visible region, front porch, sync and back porch laid end to end
   function automatic int axisTotal(input int visible, input int front,
                                    input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   localparam int DEF_H_TOTAL = axisTotal(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int DEF_V_TOTAL = axisTotal(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// Counter for one VGA axis: steps on 'advance', wraps at the axis total and
// decodes registered blank/sync flags that line up with the count they belong to.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = DEF_H_VISIBLE,
   parameter int FRONT   = DEF_H_FRONT,
   parameter int SYNC    = DEF_H_SYNC,
   parameter int BACK    = DEF_H_BACK
)
(
   input  logic  clock,
   input  logic  reset,
   input  logic  advance,
   output coordT count,
   output coordT countNext,
   output logic  wrap,
   output logic  blank,
   output logic  sync
);

   localparam int TOTAL      = axisTotal(VISIBLE, FRONT, SYNC, BACK);
   localparam int SYNC_START = VISIBLE + FRONT;
   localparam int SYNC_END   = SYNC_START + SYNC;

   localparam coordT LAST_C       = coordT'(TOTAL - 1);
   localparam coordT VISIBLE_C    = coordT'(VISIBLE);
   localparam coordT SYNC_START_C = coordT'(SYNC_START);
   localparam coordT SYNC_END_C   = coordT'(SYNC_END);

   // The axis has to fit the 11-bit counter, otherwise the wrap point would alias
   if (TOTAL > COORD_MAX) begin : genTotalTooLarge
      $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_MAX);
   end

   coordT countReg;
   logic  blankReg;
   logic  syncReg;

   // Work out where the counter lands after this edge. The flags are decoded
   // from this next value so that, once registered, they describe exactly the
   // count presented alongside them instead of lagging one cycle behind.
   always_comb begin
      countNext = countReg;
      wrap      = 1'b0;
      if (advance) begin
         if (countReg == LAST_C) begin
            countNext = '0;
            wrap      = 1'b1;
         end else begin
            countNext = countReg + coordT'(1);
         end
      end
   end

   // Count, blank and sync all live in flops; reset clears them straight away
   // so a reset in the middle of a line or frame takes effect without a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         countReg <= '0;
         blankReg <= 1'b0;
         syncReg  <= 1'b0;
      end else begin
         countReg <= countNext;
         blankReg <= (countNext >= VISIBLE_C);
         syncReg  <= (countNext >= SYNC_START_C) && (countNext < SYNC_END_C);
      end
   end

   assign count = countReg;
   assign blank = blankReg;
   assign sync  = syncReg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: 50 MHz pixel strobe from the 100 MHz clock, X/Y counters,
// blank/sync decode and a frame-start pulse. Define VGA_TIMING_FRAME_COUNT_EN to add FrameCount.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
)
(
   input  logic               CLK_100MHz,
   input  logic               RESET,
   output logic [COORD_W-1:0] CurrentX,
   output logic [COORD_W-1:0] CurrentY,
   output logic               HBlank,
   output logic               VBlank,
   output logic               HS,
   output logic               VS,
   output logic               PixEn,
   output logic               FrameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [7:0]         FrameCount
`endif
);

   logic  pixEnReg;
   logic  pixEnNext;
   logic  frameStartReg;
   logic  frameStartNext;
   coordT xCount;
   coordT xNext;
   coordT yCount;
   coordT yNext;
   logic  hWrap;
   logic  vWrap;

   // The horizontal counter steps on every pixel strobe; the vertical counter
   // steps only on the edge where the horizontal counter wraps, so a frame wrap
   // takes both counters back to zero on the same edge.
   vga_axis_counter #(
      .VISIBLE(H_VISIBLE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) hAxis (
      .clock    (CLK_100MHz),
      .reset    (RESET),
      .advance  (pixEnReg),
      .count    (xCount),
      .countNext(xNext),
      .wrap     (hWrap),
      .blank    (HBlank),
      .sync     (HS)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) vAxis (
      .clock    (CLK_100MHz),
      .reset    (RESET),
      .advance  (hWrap),
      .count    (yCount),
      .countNext(yNext),
      .wrap     (vWrap),
      .blank    (VBlank),
      .sync     (VS)
   );

   // The pixel strobe simply alternates, and frame start is decoded from the
   // values the strobe and counters are about to take so the registered pulse
   // sits exactly on the cycle showing X=0, Y=0 with the strobe high.
   always_comb begin
      pixEnNext      = ~pixEnReg;
      frameStartNext = pixEnNext && (xNext == '0) && (yNext == '0);
   end

   // Strobe and frame-start flops, cleared asynchronously with the counters.
   always_ff @(posedge CLK_100MHz or posedge RESET) begin
      if (RESET) begin
         pixEnReg      <= 1'b0;
         frameStartReg <= 1'b0;
      end else begin
         pixEnReg      <= pixEnNext;
         frameStartReg <= frameStartNext;
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] frameCountReg;

   // The vertical wrap only fires when the horizontal wrap is advancing it, so
   // it marks the single edge on which the whole frame rolls over.
   always_ff @(posedge CLK_100MHz or posedge RESET) begin
      if (RESET) begin
         frameCountReg <= '0;
      end else if (vWrap) begin
         frameCountReg <= frameCountReg + 8'd1;
      end
   end

   assign FrameCount = frameCountReg;
`else
   logic unusedFrameWrap;
   assign unusedFrameWrap = vWrap;
`endif

   assign CurrentX   = xCount;
   assign CurrentY   = yCount;
   assign PixEn      = pixEnReg;
   assign FrameStart = frameStartReg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen using a reduced timing so whole
// frames fit in a short run; define VGA_TIMING_FRAME_COUNT_EN to also check FrameCount.
module tb_vga_timing_gen;

   localparam int HV  = 8;
   localparam int HF  = 2;
   localparam int HSW = 3;
   localparam int HB  = 2;
   localparam int VV  = 4;
   localparam int VF  = 1;
   localparam int VSW = 2;
   localparam int VB  = 1;
   localparam int HT  = HV + HF + HSW + HB;
   localparam int VT  = VV + VF + VSW + VB;
   localparam int FRAME_CLKS = HT * VT * 2;

   logic        clock;
   logic        reset;
   logic [10:0] currentX;
   logic [10:0] currentY;
   logic        hBlank;
   logic        vBlank;
   logic        hSync;
   logic        vSync;
   logic        pixEn;
   logic        frameStart;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0]  frameCount;
`endif

   int checks = 0;
   int errors = 0;
   int edgesSinceRelease = 0;
   int frameStartSeen = 0;
   int hSyncClocks = 0;
   int vSyncClocks = 0;
   int hBlankClocks = 0;
   int vBlankClocks = 0;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
   ) dut (
      .CLK_100MHz(clock),
      .RESET     (reset),
      .CurrentX  (currentX),
      .CurrentY  (currentY),
      .HBlank    (hBlank),
      .VBlank    (vBlank),
      .HS        (hSync),
      .VS        (vSync),
      .PixEn     (pixEn),
      .FrameStart(frameStart)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      ,
      .FrameCount(frameCount)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         if (errors <= 30)
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: after k clean edges the strobe is high on odd k and k/2 pixels
   // have been counted; position and frame number follow by division.
   task automatic checkAgainstModel(input string tag);
      int pix;
      int x;
      int y;
      int pe;
      pix = edgesSinceRelease / 2;
      x   = pix % HT;
      y   = (pix / HT) % VT;
      pe  = edgesSinceRelease % 2;
      checkOutput({tag, ".PixEn"}, int'(pixEn), pe);
      checkOutput({tag, ".CurrentX"}, int'(currentX), x);
      checkOutput({tag, ".CurrentY"}, int'(currentY), y);
      checkOutput({tag, ".HBlank"}, int'(hBlank), (x >= HV) ? 1 : 0);
      checkOutput({tag, ".VBlank"}, int'(vBlank), (y >= VV) ? 1 : 0);
      checkOutput({tag, ".HS"}, int'(hSync), (x >= HV + HF && x < HV + HF + HSW) ? 1 : 0);
      checkOutput({tag, ".VS"}, int'(vSync), (y >= VV + VF && y < VV + VF + VSW) ? 1 : 0);
      checkOutput({tag, ".FrameStart"}, int'(frameStart), (x == 0 && y == 0 && pe == 1) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      checkOutput({tag, ".FrameCount"}, int'(frameCount), (pix / (HT * VT)) % 256);
`endif
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".PixEn"}, int'(pixEn), 0);
      checkOutput({tag, ".CurrentX"}, int'(currentX), 0);
      checkOutput({tag, ".CurrentY"}, int'(currentY), 0);
      checkOutput({tag, ".HBlank"}, int'(hBlank), 0);
      checkOutput({tag, ".VBlank"}, int'(vBlank), 0);
      checkOutput({tag, ".HS"}, int'(hSync), 0);
      checkOutput({tag, ".VS"}, int'(vSync), 0);
      checkOutput({tag, ".FrameStart"}, int'(frameStart), 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      checkOutput({tag, ".FrameCount"}, int'(frameCount), 0);
`endif
   endtask

   task automatic applyStimulus(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         edgesSinceRelease++;
         @(negedge clock);
         checkAgainstModel(tag);
         frameStartSeen += int'(frameStart);
         hSyncClocks    += int'(hSync);
         vSyncClocks    += int'(vSync);
         hBlankClocks   += int'(hBlank);
         vBlankClocks   += int'(vBlank);
      end
   endtask

   // Assert reset at a random point between edges and expect the outputs to
   // clear before the next edge, then release on a falling edge.
   task automatic pulseReset(input string tag);
      @(posedge clock);
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1;
      checkResetValues({tag, ".async"});
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkResetValues({tag, ".held"});
      reset = 1'b0;
      edgesSinceRelease = 0;
      checkAgainstModel({tag, ".release"});
   endtask

   initial begin
      reset = 1'b0;
      #2;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkResetValues("powerOnReset");
      reset = 1'b0;
      edgesSinceRelease = 0;
      checkAgainstModel("release");
      applyStimulus(6, "startup");

      for (int seg = 0; seg < 6; seg++) begin
         applyStimulus(int'($urandom_range(40, 600)), "randomRun");
         pulseReset("midRunReset");
      end

      frameStartSeen = 0;
      hSyncClocks    = 0;
      vSyncClocks    = 0;
      hBlankClocks   = 0;
      vBlankClocks   = 0;
      applyStimulus(FRAME_CLKS, "frameSweep");
      checkOutput("frameStartPerFrame", frameStartSeen, 1);
      checkOutput("hsClocksPerFrame", hSyncClocks, HSW * 2 * VT);
      checkOutput("vsClocksPerFrame", vSyncClocks, VSW * HT * 2);
      checkOutput("hBlankClocksPerFrame", hBlankClocks, (HT - HV) * 2 * VT);
      checkOutput("vBlankClocksPerFrame", vBlankClocks, (VT - VV) * HT * 2);

      applyStimulus(int'($urandom_range(2 * FRAME_CLKS, 3 * FRAME_CLKS)), "multiFrame");

`ifdef VGA_TIMING_FRAME_COUNT_EN
      pulseReset("frameCountReset");
      applyStimulus(257 * FRAME_CLKS, "frameCountRun");
      checkOutput("frameCountAfter257", int'(frameCount), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL accept parameter H_VISIBLE, default 800, visible pixels per line.
REQ-002 The block SHALL accept parameter H_FRONT, default 56, horizontal front porch in pixels.
REQ-003 The block SHALL accept parameter H_SYNC, default 120, horizontal sync width in pixels.
REQ-004 The block SHALL accept parameter H_BACK, default 64, horizontal back porch in pixels.
REQ-005 The block SHALL accept parameter V_VISIBLE, default 600, visible lines per frame.
REQ-006 The block SHALL accept parameter V_FRONT, default 37, vertical front porch in lines.
REQ-007 The block SHALL accept parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 The block SHALL accept parameter V_BACK, default 23, vertical back porch in lines.
REQ-009 CLK_100MHz  input  1  system clock; the only clock in the block.
REQ-010 RESET  input  1  asynchronous, active-high reset.
REQ-011 CurrentX  output  11  pixel column counter, 0..H_TOTAL-1 (H_TOTAL = sum of H parameters = 1040).
REQ-012 CurrentY  output  11  line counter, 0..V_TOTAL-1 (V_TOTAL = sum of V parameters = 666).
REQ-013 HBlank  output  1  high while CurrentX >= H_VISIBLE.
REQ-014 VBlank  output  1  high while CurrentY >= V_VISIBLE.
REQ-015 HS / VS  output  1 each  positive-polarity sync pulses to the connector.
REQ-016 PixEn  output  1  50 MHz pixel strobe, high on every second CLK_100MHz cycle.
REQ-017 FrameStart  output  1  one-cycle pulse, high exactly while CurrentX=0, CurrentY=0 and PixEn=1.

Function
REQ-018 PixEn SHALL toggle on every rising edge of CLK_100MHz after reset release.
REQ-019 CurrentX SHALL increment on each edge where PixEn=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-020 CurrentY SHALL increment only on the edge where CurrentX wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-021 HBlank, VBlank, HS and VS SHALL be registered and SHALL be cycle-consistent with the CurrentX/CurrentY values presented in the same cycle (zero relative latency); no output SHALL be combinational from the counters.
REQ-022 HS SHALL be high for H_VISIBLE+H_FRONT <= CurrentX < H_VISIBLE+H_FRONT+H_SYNC (856..975).
REQ-023 VS SHALL be high for V_VISIBLE+V_FRONT <= CurrentY < V_VISIBLE+V_FRONT+V_SYNC (637..642), for complete lines.
REQ-024 All counter arithmetic SHALL be 11-bit unsigned; parameter sums exceeding 2047 SHALL be rejected at elaboration.
REQ-025 Frame wrap (X=1039, Y=665, PixEn=1) SHALL return both counters to 0 on one edge, with no intermediate state.

Reset
REQ-026 While RESET=1, outputs SHALL be: PixEn=0, CurrentX=0, CurrentY=0, HBlank=0, VBlank=0, HS=0, VS=0, FrameStart=0.
REQ-027 Assertion of RESET mid-line or mid-frame SHALL clear all state immediately, without waiting for a clock edge.
REQ-028 The first edge after release SHALL set PixEn=1, and the second edge SHALL advance CurrentX to 1.

Configuration
REQ-029 With VGA_TIMING_FRAME_COUNT_EN defined, the block SHALL add output FrameCount[7:0], reset to 0, incrementing on each frame wrap and wrapping from 255 to 0.
REQ-030 Without VGA_TIMING_FRAME_COUNT_EN, the FrameCount port and its register SHALL be absent.

Structure
REQ-031 Default timing constants (800x600@72 Hz values) and the derived H_TOTAL/V_TOTAL SHALL live in shared package vga_timing_pkg.
REQ-032 One sub-module, vga_axis_counter (count, wrap, blank, and sync decode for a single axis), SHALL be instantiated twice: once for H and once for V.

Verification
REQ-033 Release reset -> PixEn pattern 1,0,1,0 on successive edges; CurrentX steps 0->1 every 2 clocks.
REQ-034 CurrentX=1039, CurrentY=10, PixEn=1 -> next edge gives CurrentX=0, CurrentY=11, HBlank=0.
REQ-035 Sweep one line -> HS high for exactly 240 clocks (X 856..975); HBlank high for X 800..1039.
REQ-036 Sweep one frame -> VS high for Y 637..642, VBlank high for Y 600..665, and exactly one FrameStart pulse per 1,385,280 clocks.
REQ-037 Assert RESET at X=500, Y=300 -> all outputs go to their reset values before the next edge; the sequence restarts as in REQ-033.
REQ-038 With VGA_TIMING_FRAME_COUNT_EN defined, run 257 frames -> FrameCount reads 1 after wrapping from 255.
